jvs_feature_tx: RTL and testbench

Device-side serializer for the JVS feature check response (command 0x14). It takes one node's capability set as the `jvs_node_info_pkg` host parser understands it and emits the feature record byte stream: 4-byte function records, then the 0x00 end code. It sits between an I/O-board emulation core and the JVS packet framer, which adds SYNC, node, length, status and checksum. The byte stream uses a valid/ready handshake.

---
 rtl/jvs_feature_tx_if.sv | 10 +
 rtl/jvs_feature_tx.sv | 251 +++++++++++++++++++++++++
 tb/tb_jvs_feature_tx.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/jvs_feature_tx_if.sv
// Byte-stream handshake between the feature-record serializer and the packet framer.
// A byte moves on a clock edge where o_valid and i_ready are both high.
interface jvs_feature_tx_if;
   logic [7:0] o_data;
   logic       o_valid;
   logic       i_ready;

   modport master (output o_data, output o_valid, input i_ready);
   modport slave  (input o_data, input o_valid, output i_ready);
endinterface

// File: rtl/jvs_feature_tx.sv
// JVS feature-check (0x14) response serializer: latches a capability set on start and
// streams the enabled 4-byte function records in ascending code order, then a 0x00 end code.
module jvs_feature_tx #(
   parameter logic [7:0] ANALOG_OUT_DEF = 8'h00,
   parameter logic [7:0] SCREEN_CH      = 8'h01
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_start,
   input  logic [3:0]  i_players,
   input  logic [7:0]  i_buttons,
   input  logic [3:0]  i_coin_slots,
   input  logic [3:0]  i_analog_ch,
   input  logic [7:0]  i_analog_bits,
   input  logic [3:0]  i_rotary_ch,
   input  logic        i_has_keycode,
   input  logic        i_has_screen_pos,
   input  logic [7:0]  i_screen_x_bits,
   input  logic [7:0]  i_screen_y_bits,
   input  logic [15:0] i_misc_digital,
   input  logic [7:0]  i_card_slots,
   input  logic [7:0]  i_hopper_ch,
   input  logic [7:0]  i_gpo,
   input  logic [3:0]  i_analog_out_ch,
   input  logic        i_has_char_disp,
   input  logic [7:0]  i_char_w,
   input  logic [7:0]  i_char_h,
   input  logic [7:0]  i_char_type,
   input  logic        i_has_backup,
   jvs_feature_tx_if.master tx,
   output logic        o_busy,
   output logic        o_done,
   output logic [7:0]  o_len
);

   typedef struct packed {
      logic [3:0]  players;
      logic [7:0]  buttons;
      logic [3:0]  coins;
      logic [3:0]  an_ch;
      logic [7:0]  an_bits;
      logic [3:0]  rot_ch;
      logic        keycode;
      logic        screen;
      logic [7:0]  sx;
      logic [7:0]  sy;
      logic [15:0] misc;
      logic [7:0]  card;
      logic [7:0]  hopper;
      logic [7:0]  gpo;
      logic [3:0]  aout_ch;
      logic        chr;
      logic [7:0]  chr_w;
      logic [7:0]  chr_h;
      logic [7:0]  chr_t;
      logic        backup;
   } cap_t;

   typedef enum logic [1:0] {S_IDLE, S_REC, S_END} state_t;

   function automatic logic [12:0] f_enable(input cap_t c);
      logic [12:0] en;
      en[0]  = (c.players != 4'd0);
      en[1]  = (c.coins != 4'd0);
      en[2]  = (c.an_ch != 4'd0);
      en[3]  = (c.rot_ch != 4'd0);
      en[4]  = c.keycode;
      en[5]  = c.screen;
      en[6]  = (c.misc != 16'd0);
      en[7]  = (c.card != 8'd0);
      en[8]  = (c.hopper != 8'd0);
      en[9]  = (c.gpo != 8'd0);
      en[10] = (c.aout_ch != 4'd0);
      en[11] = c.chr;
      en[12] = c.backup;
      return en;
   endfunction

   // pos 0 is the function code, pos 1..3 the parameter bytes
   function automatic logic [7:0] f_byte(input cap_t c, input logic [3:0] idx, input logic [1:0] pos);
      logic [7:0] code, p1, p2, p3;
      code = 8'h00;
      p1   = ANALOG_OUT_DEF;
      p2   = ANALOG_OUT_DEF;
      p3   = ANALOG_OUT_DEF;
      case (idx)
         4'd0:  begin code = 8'h01; p1 = {4'h0, c.players}; p2 = c.buttons; end
         4'd1:  begin code = 8'h02; p1 = {4'h0, c.coins}; end
         4'd2:  begin code = 8'h03; p1 = {4'h0, c.an_ch}; p2 = c.an_bits; end
         4'd3:  begin code = 8'h04; p1 = {4'h0, c.rot_ch}; end
         4'd4:  code = 8'h05;
         4'd5:  begin code = 8'h06; p1 = c.sx; p2 = c.sy; p3 = SCREEN_CH; end
         4'd6:  begin code = 8'h07; p1 = c.misc[15:8]; p2 = c.misc[7:0]; end
         4'd7:  begin code = 8'h10; p1 = c.card; end
         4'd8:  begin code = 8'h11; p1 = c.hopper; end
         4'd9:  begin code = 8'h12; p1 = c.gpo; end
         4'd10: begin code = 8'h13; p1 = {4'h0, c.aout_ch}; end
         4'd11: begin code = 8'h14; p1 = c.chr_w; p2 = c.chr_h; p3 = c.chr_t; end
         4'd12: code = 8'h15;
         default: code = 8'h00;
      endcase
      case (pos)
         2'd0:    return code;
         2'd1:    return p1;
         2'd2:    return p2;
         default: return p3;
      endcase
   endfunction

   // Lowest enabled index >= from, as {found, index}
   function automatic logic [4:0] f_next(input logic [12:0] en, input logic [3:0] from);
      logic [4:0] r;
      r = 5'd0;
      for (int i = 12; i >= 0; i--) begin
         if (en[i] && (4'(i) >= from)) r = {1'b1, 4'(i)};
      end
      return r;
   endfunction

   state_t      r_state, w_state_next;
   cap_t        r_cap, w_cap_next, w_cap_in;
   logic [3:0]  r_idx, w_idx_next;
   logic [1:0]  r_byte, w_byte_next;
   logic [7:0]  r_data, w_data_next;
   logic        r_valid, w_valid_next;
   logic        r_busy, w_busy_next;
   logic        r_done, w_done_next;
   logic [7:0]  r_len, w_len_next;
   logic        w_fire;
   logic [4:0]  w_first, w_after;

   always_comb begin
      w_cap_in         = '0;
      w_cap_in.players = i_players;
      w_cap_in.buttons = i_buttons;
      w_cap_in.coins   = i_coin_slots;
      w_cap_in.an_ch   = i_analog_ch;
      w_cap_in.an_bits = i_analog_bits;
      w_cap_in.rot_ch  = i_rotary_ch;
      w_cap_in.keycode = i_has_keycode;
      w_cap_in.screen  = i_has_screen_pos;
      w_cap_in.sx      = i_screen_x_bits;
      w_cap_in.sy      = i_screen_y_bits;
      w_cap_in.misc    = i_misc_digital;
      w_cap_in.card    = i_card_slots;
      w_cap_in.hopper  = i_hopper_ch;
      w_cap_in.gpo     = i_gpo;
      w_cap_in.aout_ch = i_analog_out_ch;
      w_cap_in.chr     = i_has_char_disp;
      w_cap_in.chr_w   = i_char_w;
      w_cap_in.chr_h   = i_char_h;
      w_cap_in.chr_t   = i_char_type;
      w_cap_in.backup  = i_has_backup;
   end

   assign w_fire  = r_valid & tx.i_ready;
   // The first record comes straight from the live inputs so its code is ready on the next edge
   assign w_first = f_next(f_enable(w_cap_in), 4'd0);
   assign w_after = f_next(f_enable(r_cap), r_idx + 4'd1);

   always_comb begin
      w_state_next = r_state;
      w_cap_next   = r_cap;
      w_idx_next   = r_idx;
      w_byte_next  = r_byte;
      w_data_next  = r_data;
      w_valid_next = r_valid;
      w_busy_next  = r_busy;
      w_done_next  = 1'b0;
      w_len_next   = r_len;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_cap_next   = w_cap_in;
               w_len_next   = 8'd0;
               w_busy_next  = 1'b1;
               w_valid_next = 1'b1;
               w_byte_next  = 2'd0;
               if (w_first[4]) begin
                  w_state_next = S_REC;
                  w_idx_next   = w_first[3:0];
                  w_data_next  = f_byte(w_cap_in, w_first[3:0], 2'd0);
               end else begin
                  w_state_next = S_END;
                  w_data_next  = 8'h00;
               end
            end
         end
         S_REC: begin
            if (w_fire) begin
               w_len_next = r_len + 8'd1;
               if (r_byte != 2'd3) begin
                  w_byte_next = r_byte + 2'd1;
                  w_data_next = f_byte(r_cap, r_idx, r_byte + 2'd1);
               end else begin
                  w_byte_next = 2'd0;
                  if (w_after[4]) begin
                     w_idx_next  = w_after[3:0];
                     w_data_next = f_byte(r_cap, w_after[3:0], 2'd0);
                  end else begin
                     w_state_next = S_END;
                     w_data_next  = 8'h00;
                  end
               end
            end
         end
         S_END: begin
            if (w_fire) begin
               w_len_next   = r_len + 8'd1;
               w_valid_next = 1'b0;
               w_busy_next  = 1'b0;
               w_done_next  = 1'b1;
               w_data_next  = 8'h00;
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cap   <= '0;
         r_idx   <= 4'd0;
         r_byte  <= 2'd0;
         r_data  <= 8'h00;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_len   <= 8'd0;
      end else begin
         r_state <= w_state_next;
         r_cap   <= w_cap_next;
         r_idx   <= w_idx_next;
         r_byte  <= w_byte_next;
         r_data  <= w_data_next;
         r_valid <= w_valid_next;
         r_busy  <= w_busy_next;
         r_done  <= w_done_next;
         r_len   <= w_len_next;
      end
   end

   assign tx.o_data  = r_data;
   assign tx.o_valid = r_valid;
   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_len      = r_len;

endmodule

// File: tb/tb_jvs_feature_tx.sv
// Scoreboard bench for jvs_feature_tx: stimulus queues expected bytes, a negedge monitor
// pops and compares every accepted byte and checks stall stability.
module tb_jvs_feature_tx;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_start = 1'b0;
   logic [3:0]  i_players, i_coin_slots, i_analog_ch, i_rotary_ch, i_analog_out_ch;
   logic [7:0]  i_buttons, i_analog_bits, i_screen_x_bits, i_screen_y_bits;
   logic [7:0]  i_card_slots, i_hopper_ch, i_gpo, i_char_w, i_char_h, i_char_type;
   logic [15:0] i_misc_digital;
   logic        i_has_keycode, i_has_screen_pos, i_has_char_disp, i_has_backup;
   logic        o_busy, o_done;
   logic [7:0]  o_len;

   jvs_feature_tx_if bus();

   jvs_feature_tx dut (
      .clk(clk), .rst(rst), .i_start(i_start),
      .i_players(i_players), .i_buttons(i_buttons), .i_coin_slots(i_coin_slots),
      .i_analog_ch(i_analog_ch), .i_analog_bits(i_analog_bits), .i_rotary_ch(i_rotary_ch),
      .i_has_keycode(i_has_keycode), .i_has_screen_pos(i_has_screen_pos),
      .i_screen_x_bits(i_screen_x_bits), .i_screen_y_bits(i_screen_y_bits),
      .i_misc_digital(i_misc_digital), .i_card_slots(i_card_slots), .i_hopper_ch(i_hopper_ch),
      .i_gpo(i_gpo), .i_analog_out_ch(i_analog_out_ch), .i_has_char_disp(i_has_char_disp),
      .i_char_w(i_char_w), .i_char_h(i_char_h), .i_char_type(i_char_type),
      .i_has_backup(i_has_backup), .tx(bus.master),
      .o_busy(o_busy), .o_done(o_done), .o_len(o_len)
   );

   always #5 clk = ~clk;

   logic [7:0] exp_q[$];
   int n_vec  = 0;
   int n_fail = 0;
   int rdy_mode = 0;

   logic [7:0] two_exp [9]  = '{8'h01,8'h02,8'h0D,8'h00, 8'h02,8'h02,8'h00,8'h00, 8'h00};
   logic [7:0] mix_exp [13] = '{8'h03,8'h02,8'h00,8'h00, 8'h11,8'h03,8'h00,8'h00,
                                8'h15,8'h00,8'h00,8'h00, 8'h00};
   logic [7:0] full_exp [53] = '{
      8'h01,8'h03,8'h0C,8'h00,  8'h02,8'h02,8'h00,8'h00,  8'h03,8'h08,8'h0A,8'h00,
      8'h04,8'h04,8'h00,8'h00,  8'h05,8'h00,8'h00,8'h00,  8'h06,8'h10,8'h0E,8'h01,
      8'h07,8'h12,8'h34,8'h00,  8'h10,8'h01,8'h00,8'h00,  8'h11,8'h05,8'h00,8'h00,
      8'h12,8'h18,8'h00,8'h00,  8'h13,8'h02,8'h00,8'h00,  8'h14,8'h14,8'h02,8'h01,
      8'h15,8'h00,8'h00,8'h00,  8'h00};

   // Ready driver: constant high, or a fixed stall pattern
   initial begin
      logic [7:0] pat;
      int k;
      pat = 8'b1001_0110;
      k = 0;
      bus.i_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         if (rdy_mode == 0) bus.i_ready = 1'b1;
         else bus.i_ready = pat[k % 8];
         k++;
      end
   end

   // Monitor: every accepted byte is compared with the head of the scoreboard
   logic       stall_prev = 1'b0;
   logic [7:0] held = 8'h00;
   always @(negedge clk) begin
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            n_vec++;
            if (!(bus.o_valid === 1'b1 && bus.o_data === held)) begin
               n_fail++;
               $display("FAIL hold: valid=%b data=%02h, required valid=1 data=%02h",
                        bus.o_valid, bus.o_data, held);
            end
         end
         if (bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL byte: unexpected byte %02h, no byte required", bus.o_data);
            end else begin
               logic [7:0] e;
               e = exp_q.pop_front();
               if (bus.o_data !== e) begin
                  n_fail++;
                  $display("FAIL byte: got %02h required %02h", bus.o_data, e);
               end
            end
         end
         stall_prev = (bus.o_valid === 1'b1) && (bus.i_ready !== 1'b1);
         held = bus.o_data;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   task automatic clear_caps();
      i_players = 0; i_buttons = 0; i_coin_slots = 0; i_analog_ch = 0; i_analog_bits = 0;
      i_rotary_ch = 0; i_has_keycode = 0; i_has_screen_pos = 0; i_screen_x_bits = 0;
      i_screen_y_bits = 0; i_misc_digital = 0; i_card_slots = 0; i_hopper_ch = 0; i_gpo = 0;
      i_analog_out_ch = 0; i_has_char_disp = 0; i_char_w = 0; i_char_h = 0; i_char_type = 0;
      i_has_backup = 0;
   endtask

   task automatic set_two();
      clear_caps();
      i_players = 4'd2; i_buttons = 8'd13; i_coin_slots = 4'd2;
   endtask

   task automatic set_mix();
      clear_caps();
      i_analog_ch = 4'd2; i_analog_bits = 8'd0; i_hopper_ch = 8'd3; i_has_backup = 1'b1;
   endtask

   task automatic set_full();
      clear_caps();
      i_players = 4'd3; i_buttons = 8'h0C; i_coin_slots = 4'd2; i_analog_ch = 4'd8;
      i_analog_bits = 8'h0A; i_rotary_ch = 4'd4; i_has_keycode = 1'b1; i_has_screen_pos = 1'b1;
      i_screen_x_bits = 8'h10; i_screen_y_bits = 8'h0E; i_misc_digital = 16'h1234;
      i_card_slots = 8'h01; i_hopper_ch = 8'h05; i_gpo = 8'h18; i_analog_out_ch = 4'd2;
      i_has_char_disp = 1'b1; i_char_w = 8'h14; i_char_h = 8'h02; i_char_type = 8'h01;
      i_has_backup = 1'b1;
   endtask

   // Called at posedge+2; the start is sampled on the following edge
   task automatic start_resp();
      i_start = 1'b1;
      @(posedge clk);
      #2;
      i_start = 1'b0;
      chk("first_valid", {31'd0, bus.o_valid}, 32'd1);
      chk("first_busy", {31'd0, o_busy}, 32'd1);
      chk("first_len", {24'd0, o_len}, 32'd0);
      chk("done_pulse", {31'd0, o_done}, 32'd0);
   endtask

   // Returns in the o_done cycle; lat < 0 skips the latency check
   task automatic wait_done(input string name, input int n, input int lat);
      int cyc;
      cyc = 0;
      while (o_done !== 1'b1 && cyc < 400) begin
         @(posedge clk);
         #2;
         cyc++;
      end
      if (o_done !== 1'b1) begin
         chk({name, "_timeout"}, 32'd0, 32'd1);
      end else begin
         if (lat >= 0) chk({name, "_latency"}, cyc, lat);
         chk({name, "_done_valid"}, {31'd0, bus.o_valid}, 32'd0);
         chk({name, "_done_busy"}, {31'd0, o_busy}, 32'd0);
         chk({name, "_len"}, {24'd0, o_len}, n);
         chk({name, "_left"}, exp_q.size(), 32'd0);
      end
      $display("txn %s: len=%0d cycles=%0d pending=%0d", name, o_len, cyc, exp_q.size());
   endtask

   initial begin
      int vcount;
      clear_caps();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_valid", {31'd0, bus.o_valid}, 32'd0);
      chk("rst_busy", {31'd0, o_busy}, 32'd0);
      chk("rst_done", {31'd0, o_done}, 32'd0);
      chk("rst_len", {24'd0, o_len}, 32'd0);
      chk("rst_data", {24'd0, bus.o_data}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #2;

      rdy_mode = 0;
      foreach (two_exp[i]) exp_q.push_back(two_exp[i]);
      set_two();
      start_resp();
      wait_done("two_player", 9, 9);

      // Back-to-back start in the done cycle
      clear_caps();
      exp_q.push_back(8'h00);
      start_resp();
      wait_done("empty", 1, 1);

      foreach (mix_exp[i]) exp_q.push_back(mix_exp[i]);
      set_mix();
      start_resp();
      wait_done("skip_mix", 13, 13);

      foreach (full_exp[i]) exp_q.push_back(full_exp[i]);
      set_full();
      start_resp();
      wait_done("full", 53, 53);

      rdy_mode = 1;
      foreach (full_exp[i]) exp_q.push_back(full_exp[i]);
      set_full();
      start_resp();
      wait_done("backpressure", 53, -1);

      // Start pulse and capability change in flight must not disturb the stream
      foreach (full_exp[i]) exp_q.push_back(full_exp[i]);
      set_full();
      start_resp();
      repeat (10) @(posedge clk);
      #2;
      set_two();
      i_start = 1'b1;
      @(posedge clk);
      #2;
      i_start = 1'b0;
      wait_done("ignored_start", 53, -1);
      vcount = 0;
      repeat (8) begin
         @(posedge clk);
         #2;
         if (bus.o_valid === 1'b1) vcount++;
      end
      chk("no_second_resp", vcount, 32'd0);

      // Reset while byte 5 is presented
      rdy_mode = 0;
      foreach (full_exp[i]) exp_q.push_back(full_exp[i]);
      set_full();
      start_resp();
      vcount = 0;
      while (o_len !== 8'd4 && vcount < 20) begin
         @(posedge clk);
         #2;
         vcount++;
      end
      chk("pre_rst_len", {24'd0, o_len}, 32'd4);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", {31'd0, bus.o_valid}, 32'd0);
      chk("mid_rst_busy", {31'd0, o_busy}, 32'd0);
      chk("mid_rst_len", {24'd0, o_len}, 32'd0);
      exp_q.delete();
      $display("txn mid_reset: stream aborted after 4 bytes");
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      foreach (full_exp[i]) exp_q.push_back(full_exp[i]);
      start_resp();
      wait_done("after_reset", 53, 53);

      @(posedge clk);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
